// File: rtl/dlx_mem_initiator_if.sv
// Request/response and memory-control signals of the DLX memory initiator.
// The shared data bus stays a plain inout port on the initiator itself.
interface dlx_mem_initiator_if #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 16
);

  // Datapath side
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    resp_valid;
  logic [WORD_SIZE-1:0]    resp_rdata;
  logic                    resp_err;

  // Memory side
  logic                    ENABLE;
  logic                    READNOTWRITE;
  logic [ADDRESS_SIZE-1:0] ADDRESS;
  logic                    DATA_READY;

  // The initiator
  modport master (
    input  req_valid,
    output req_ready,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output ENABLE,
    output READNOTWRITE,
    output ADDRESS,
    input  DATA_READY
  );

  // Requester plus memory seen from the other side
  modport slave (
    output req_valid,
    input  req_ready,
    output req_we,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  ENABLE,
    input  READNOTWRITE,
    input  ADDRESS,
    output DATA_READY
  );

endinterface

// File: rtl/dlx_mem_initiator.sv
// DLX memory interface initiator: turns single-beat load/store requests into
// ENABLE/READNOTWRITE/ADDRESS/INOUT_DATA/DATA_READY transactions and returns
// one response per request.
// Optional feature macro: DLX_MEM_TIMEOUT_EN (bounded WAIT with resp_err).
module dlx_mem_initiator #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned ADDRESS_SIZE   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dlx_mem_initiator_if.master   bus,
  inout  wire  [WORD_SIZE-1:0]  INOUT_DATA
);

  typedef enum logic [1:0] {StIdle, StSetup, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    we_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic                    accept;
  logic                    complete;
  logic                    timeout;
  logic                    enable;

`ifdef DLX_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and transaction events
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = StSetup;
        end
      end
      // DATA_READY may still be high from the previous access, so never look at it here
      StSetup: state_d = StWait;
      StWait: begin
        if (bus.DATA_READY) begin
          complete = 1'b1;
          state_d  = StResp;
`ifdef DLX_MEM_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = StResp;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response data: bus sample for loads, zero for stores and aborts; held until next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (complete) begin
      rdata_q <= we_q ? '0 : INOUT_DATA;
    end else if (timeout) begin
      rdata_q <= '0;
    end
  end

`ifdef DLX_MEM_TIMEOUT_EN
  // WAIT-cycle counter, zeroed when a request is taken so SETUP enters WAIT at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Error flag refreshed at every response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (complete) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign bus.resp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign bus.resp_err       = 1'b0;
`endif

  // Outputs decoded from the (asynchronously reset) state so reset takes effect at once
  always_comb begin
    enable           = (state_q == StSetup) || (state_q == StWait);
    bus.ENABLE       = enable;
    bus.READNOTWRITE = enable ? ~we_q : 1'b1;
    bus.ADDRESS      = addr_q;
    bus.req_ready    = (state_q == StIdle);
    bus.resp_valid   = (state_q == StResp);
    bus.resp_rdata   = rdata_q;
  end

  // Drive the shared bus only during an active write
  assign INOUT_DATA = (enable && we_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_dlx_mem_initiator.sv
// Self-checking bench for dlx_mem_initiator: table of load/store vectors,
// scoreboard of expected responses, plus reset, back-to-back and timeout sequences.
module tb_dlx_mem_initiator;

  localparam int unsigned W  = 32;
  localparam int unsigned A  = 16;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dlx_mem_initiator_if #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) bus_if ();
  wire [W-1:0] data_bus;

  dlx_mem_initiator #(
    .WORD_SIZE      (W),
    .ADDRESS_SIZE   (A),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .INOUT_DATA (data_bus)
  );

  // Memory model: sticky ready flag raised 'mem_delay' enabled cycles into an access
  logic [W-1:0] mem [0:65535];
  logic         mem_ready = 1'b0;
  int           mem_delay = 1;
  int           en_cnt    = 0;

  assign data_bus          = (bus_if.ENABLE && bus_if.READNOTWRITE) ? mem[bus_if.ADDRESS] : 'z;
  assign bus_if.DATA_READY = mem_ready;

  always @(posedge clk) begin
    if (bus_if.ENABLE) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt + 1 >= mem_delay) begin
        mem_ready <= 1'b1;
        if (!bus_if.READNOTWRITE) mem[bus_if.ADDRESS] <= data_bus;
      end else begin
        mem_ready <= 1'b0;
      end
    end else begin
      en_cnt <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  typedef struct {
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    int           delay;
    logic [W-1:0] exp_rdata;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[8];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] cur_wdata = '0;
  int           last_resp_cyc = 0;
  int           en_low_run = 0;
  int           last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic bus_free(input logic [W-1:0] v);
    for (int i = 0; i < int'(W); i++) begin
      if (v[i] === 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Response and bus monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.resp_valid) begin
          last_resp_cyc = cyc;
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'(bus_if.resp_valid), 32'(0));
          end else begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, bus_if.resp_rdata, e.rdata);
            check({e.name, "_err"}, 32'(bus_if.resp_err), 32'(e.err));
            check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          end
        end
        if (bus_if.ENABLE && !bus_if.READNOTWRITE) begin
          check("bus_write_data", data_bus, cur_wdata);
        end else if (!bus_if.ENABLE) begin
          check("bus_released", 32'(bus_free(data_bus)), 32'(1));
        end
        if (!bus_if.ENABLE) begin
          en_low_run++;
        end else if (en_low_run > 0) begin
          last_gap   = en_low_run;
          en_low_run = 0;
        end
      end
    end
  end

  // Issue one request when the controller is idle; scrambles the request fields afterwards
  task automatic send(input logic we, input logic [A-1:0] addr, input logic [W-1:0] wdata,
                      input int delay, input logic [W-1:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input string name);
    int n = 0;
    @(negedge clk);
    while (!bus_if.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.req_ready) begin
      check({name, "_ready_timeout"}, 32'(bus_if.req_ready), 32'(1));
      return;
    end
    mem_delay        = delay;
    cur_wdata        = wdata;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    sb.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc + 1, lat: exp_lat, name: name});
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'($urandom);
    bus_if.req_addr  = A'($urandom);
    bus_if.req_wdata = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_resp_timeout"}, 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 2, 32'h0,        1'b0, 3};
    vecs[1] = '{1'b0, 16'h0004, 32'h0,        1, 32'hDEADBEEF, 1'b0, 2};
    vecs[2] = '{1'b1, 16'hFFFF, 32'h12345678, 1, 32'h0,        1'b0, 2};
    vecs[3] = '{1'b1, 16'h0000, 32'hA5A55A5A, 3, 32'h0,        1'b0, 4};
    vecs[4] = '{1'b0, 16'h0004, 32'h0,        2, 32'hDEADBEEF, 1'b0, 3};
    vecs[5] = '{1'b1, 16'h1234, 32'hCAFEF00D, 1, 32'h0,        1'b0, 2};
    vecs[6] = '{1'b0, 16'h1234, 32'h0,        4, 32'hCAFEF00D, 1'b0, 5};
    vecs[7] = '{1'b0, 16'hFFFF, 32'h0,        1, 32'h12345678, 1'b0, 2};

    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    rst = 1'b1;
    #1;
    check("rst_req_ready",  32'(bus_if.req_ready),    32'(1));
    check("rst_resp_valid", 32'(bus_if.resp_valid),   32'(0));
    check("rst_resp_rdata", bus_if.resp_rdata,        32'h0);
    check("rst_resp_err",   32'(bus_if.resp_err),     32'(0));
    check("rst_enable",     32'(bus_if.ENABLE),       32'(0));
    check("rst_rnw",        32'(bus_if.READNOTWRITE), 32'(1));
    check("rst_address",    32'(bus_if.ADDRESS),      32'(0));
    check("rst_bus_free",   32'(bus_free(data_bus)),  32'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven loads and stores
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay, vecs[i].exp_rdata,
           vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
    end
    check("mem_0004", mem[16'h0004], 32'hDEADBEEF);
    check("mem_ffff", mem[16'hFFFF], 32'h12345678);
    check("mem_0000", mem[16'h0000], 32'hA5A55A5A);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    mem_delay        = 1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 16'h0000;
    sb.push_back('{rdata: 32'hA5A55A5A, err: 1'b0, acc: cyc + 1, lat: 2, name: "b2b_first"});
    @(negedge clk);
    bus_if.req_addr = 16'hFFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.req_ready && n < 50);
    check("b2b_accept_gap", 32'(cyc - last_resp_cyc), 32'(1));
    check("b2b_idle_enable", 32'(bus_if.ENABLE), 32'(0));
    sb.push_back('{rdata: 32'h12345678, err: 1'b0, acc: cyc + 1, lat: 2, name: "b2b_second"});
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("b2b_setup_enable", 32'(bus_if.ENABLE), 32'(1));
    @(negedge clk);
    check("b2b_enable_gap", 32'(last_gap), 32'(2));
    wait_idle("b2b");

`ifdef DLX_MEM_TIMEOUT_EN
    // Memory never answers: abort after TO WAIT cycles, data forced to zero
    send(1'b0, 16'h0004, 32'h0, 1000, 32'h0, 1'b1, TO + 1, "timeout_abort");
    wait_idle("timeout_abort");
    // Ready on the last WAIT cycle beats the timeout
    send(1'b0, 16'h1234, 32'h0, TO, 32'hCAFEF00D, 1'b0, TO + 1, "timeout_race");
    wait_idle("timeout_race");
`else
    // Without the timeout feature WAIT is unbounded
    send(1'b0, 16'h1234, 32'h0, 20, 32'hCAFEF00D, 1'b0, 21, "long_wait");
    wait_idle("long_wait");
`endif

    // Reset during WAIT of a write to 0x0010
    send(1'b1, 16'h0010, 32'h0BADF00D, 100, 32'h0, 1'b0, 0, "dropped_write");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_enable",     32'(bus_if.ENABLE),       32'(0));
    check("midrst_bus_free",   32'(bus_free(data_bus)),  32'(1));
    check("midrst_req_ready",  32'(bus_if.req_ready),    32'(1));
    check("midrst_resp_valid", 32'(bus_if.resp_valid),   32'(0));
    check("midrst_resp_rdata", bus_if.resp_rdata,        32'h0);
    check("midrst_rnw",        32'(bus_if.READNOTWRITE), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_req_ready", 32'(bus_if.req_ready), 32'(1));
    end

    // Normal operation resumes after reset
    send(1'b0, 16'h0004, 32'h0, 1, 32'hDEADBEEF, 1'b0, 2, "postrst_load");
    wait_idle("postrst_load");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
